// File: rtl/morse_word_serializer_pkg.sv
// Shared constants for the Morse word serializer: character geometry,
// decoder code points, output byte values and the serializer FSM encoding.
package morse_word_serializer_pkg;

  // Decoded word geometry
  localparam int CHAR_W_DEF    = 6;
  localparam int MAX_CHARS_DEF = 8;

  // Decoder code points (code 0 marks an empty slot)
  localparam int unsigned CHAR_MORSE_A = 1,  CHAR_MORSE_B = 2,  CHAR_MORSE_C = 3;
  localparam int unsigned CHAR_MORSE_D = 4,  CHAR_MORSE_E = 5,  CHAR_MORSE_F = 6;
  localparam int unsigned CHAR_MORSE_G = 7,  CHAR_MORSE_H = 8,  CHAR_MORSE_I = 9;
  localparam int unsigned CHAR_MORSE_J = 10, CHAR_MORSE_K = 11, CHAR_MORSE_L = 12;
  localparam int unsigned CHAR_MORSE_M = 13, CHAR_MORSE_N = 14, CHAR_MORSE_O = 15;
  localparam int unsigned CHAR_MORSE_P = 16, CHAR_MORSE_Q = 17, CHAR_MORSE_R = 18;
  localparam int unsigned CHAR_MORSE_S = 19, CHAR_MORSE_T = 20, CHAR_MORSE_U = 21;
  localparam int unsigned CHAR_MORSE_V = 22, CHAR_MORSE_W = 23, CHAR_MORSE_X = 24;
  localparam int unsigned CHAR_MORSE_Y = 25, CHAR_MORSE_Z = 26;
  localparam int unsigned CHAR_MORSE_0 = 27, CHAR_MORSE_1 = 28, CHAR_MORSE_2 = 29;
  localparam int unsigned CHAR_MORSE_3 = 30, CHAR_MORSE_4 = 31, CHAR_MORSE_5 = 32;
  localparam int unsigned CHAR_MORSE_6 = 33, CHAR_MORSE_7 = 34, CHAR_MORSE_8 = 35;
  localparam int unsigned CHAR_MORSE_9 = 36;

  // Output byte values
  localparam logic [7:0] SEP_CHAR_DEF = 8'h20;
  localparam logic [7:0] ERR_CHAR_DEF = 8'h23;
  localparam logic [7:0] UNK_CHAR_DEF = 8'h3F;

  // Serializer FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CHAR = 3'd2,
    ST_SEP  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/morse_word_serializer_char_to_ascii.sv
// Combinational decoder-code to ASCII lookup, shared with the display path.
// Code 0 (empty slot) yields 8'h00; any other unmapped code yields UNK_CHAR.
module morse_char_to_ascii
  import morse_word_serializer_pkg::*;
#(
  parameter int         CHAR_W   = CHAR_W_DEF,
  parameter logic [7:0] UNK_CHAR = UNK_CHAR_DEF
) (
  input  logic [CHAR_W-1:0] code_i,
  output logic [7:0]        ascii_o
);

  logic [31:0] code_ext;

  // Table lookup of one character code
  always_comb begin
    code_ext = '0;
    code_ext[CHAR_W-1:0] = code_i;
    ascii_o = UNK_CHAR;
    case (code_ext)
      32'd0:        ascii_o = 8'h00;
      CHAR_MORSE_A: ascii_o = 8'h41;
      CHAR_MORSE_B: ascii_o = 8'h42;
      CHAR_MORSE_C: ascii_o = 8'h43;
      CHAR_MORSE_D: ascii_o = 8'h44;
      CHAR_MORSE_E: ascii_o = 8'h45;
      CHAR_MORSE_F: ascii_o = 8'h46;
      CHAR_MORSE_G: ascii_o = 8'h47;
      CHAR_MORSE_H: ascii_o = 8'h48;
      CHAR_MORSE_I: ascii_o = 8'h49;
      CHAR_MORSE_J: ascii_o = 8'h4A;
      CHAR_MORSE_K: ascii_o = 8'h4B;
      CHAR_MORSE_L: ascii_o = 8'h4C;
      CHAR_MORSE_M: ascii_o = 8'h4D;
      CHAR_MORSE_N: ascii_o = 8'h4E;
      CHAR_MORSE_O: ascii_o = 8'h4F;
      CHAR_MORSE_P: ascii_o = 8'h50;
      CHAR_MORSE_Q: ascii_o = 8'h51;
      CHAR_MORSE_R: ascii_o = 8'h52;
      CHAR_MORSE_S: ascii_o = 8'h53;
      CHAR_MORSE_T: ascii_o = 8'h54;
      CHAR_MORSE_U: ascii_o = 8'h55;
      CHAR_MORSE_V: ascii_o = 8'h56;
      CHAR_MORSE_W: ascii_o = 8'h57;
      CHAR_MORSE_X: ascii_o = 8'h58;
      CHAR_MORSE_Y: ascii_o = 8'h59;
      CHAR_MORSE_Z: ascii_o = 8'h5A;
      CHAR_MORSE_0: ascii_o = 8'h30;
      CHAR_MORSE_1: ascii_o = 8'h31;
      CHAR_MORSE_2: ascii_o = 8'h32;
      CHAR_MORSE_3: ascii_o = 8'h33;
      CHAR_MORSE_4: ascii_o = 8'h34;
      CHAR_MORSE_5: ascii_o = 8'h35;
      CHAR_MORSE_6: ascii_o = 8'h36;
      CHAR_MORSE_7: ascii_o = 8'h37;
      CHAR_MORSE_8: ascii_o = 8'h38;
      CHAR_MORSE_9: ascii_o = 8'h39;
      default:      ascii_o = UNK_CHAR;
    endcase
  end

endmodule

// File: rtl/morse_word_serializer.sv
// Buffers completed decoded words (2-entry FIFO) and streams them out as
// ASCII bytes over valid/ready, each word followed by a separator byte.
// A FIFO entry stays occupied until its separator is accepted, so the word
// being serialized counts against the buffer depth.
module morse_word_serializer
  import morse_word_serializer_pkg::*;
#(
  parameter int         CHAR_W    = CHAR_W_DEF,
  parameter int         MAX_CHARS = MAX_CHARS_DEF,
  parameter logic [7:0] SEP_CHAR  = SEP_CHAR_DEF,
  parameter logic [7:0] ERR_CHAR  = ERR_CHAR_DEF,
  parameter logic [7:0] UNK_CHAR  = UNK_CHAR_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic [CHAR_W*MAX_CHARS-1:0] word,
  input  logic                        word_ended,
  input  logic                        error,
  output logic [7:0]                  ascii_data,
  output logic                        ascii_valid,
  input  logic                        ascii_ready,
  output logic                        dropped,
  output logic                        busy
);

  localparam int WORD_W = CHAR_W * MAX_CHARS;
  localparam int IDX_W  = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  // Edge detector and FIFO control
  logic             we_prev_q, we_prev_d;
  logic             dropped_q, dropped_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             evt, word_empty, full, push, pop, drop;

  // FIFO storage (data only, not reset)
  logic [WORD_W-1:0] mem_word_q [2];
  logic [1:0]        mem_err_q;

  // Serializer
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] shift_nxt;
  logic [7:0]        char_ascii;

  assign shift_nxt = shift_q >> CHAR_W;

  morse_char_to_ascii #(
    .CHAR_W   (CHAR_W),
    .UNK_CHAR (UNK_CHAR)
  ) u_lookup (
    .code_i  (shift_q[CHAR_W-1:0]),
    .ascii_o (char_ascii)
  );

  // Word-event detection, push/pop/drop decisions and FIFO bookkeeping
  always_comb begin
    evt        = ce & word_ended & ~we_prev_q;
    word_empty = (word == '0) & ~error;
    full       = (cnt_q == 2'd2);
    pop        = (state_q == ST_SEP) & ascii_ready;
    push       = evt & ~word_empty & (~full | pop);
    drop       = evt & ~word_empty & full & ~pop;
    we_prev_d  = ce ? word_ended : we_prev_q;
    dropped_d  = drop;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
  end

  // FSM next state, slot walk and output presentation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    ascii_valid = 1'b0;
    ascii_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if ((cnt_q != 2'd0) || push) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = mem_word_q[rd_ptr_q];
        idx_d   = '0;
        state_d = mem_err_q[rd_ptr_q] ? ST_ERR : ST_CHAR;
      end
      ST_CHAR: begin
        ascii_valid = 1'b1;
        ascii_data  = char_ascii;
        if (ascii_ready) begin
          if ((idx_q == IDX_W'(MAX_CHARS - 1)) || (shift_nxt[CHAR_W-1:0] == '0)) begin
            state_d = ST_SEP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_nxt;
          end
        end
      end
      ST_SEP: begin
        ascii_valid = 1'b1;
        ascii_data  = SEP_CHAR;
        if (ascii_ready) state_d = ((cnt_q > 2'd1) || push) ? ST_LOAD : ST_IDLE;
      end
      ST_ERR: begin
        ascii_valid = 1'b1;
        ascii_data  = ERR_CHAR;
        if (ascii_ready) state_d = ST_SEP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      we_prev_q <= 1'b0;
      dropped_q <= 1'b0;
      cnt_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      state_q   <= ST_IDLE;
      idx_q     <= '0;
    end else begin
      we_prev_q <= we_prev_d;
      dropped_q <= dropped_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
    end
  end

  // Data registers: FIFO write and character shift register
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word_q[wr_ptr_q] <= word;
      mem_err_q[wr_ptr_q]  <= error;
    end
    shift_q <= shift_d;
  end

  assign dropped = dropped_q;
  assign busy    = (cnt_q != 2'd0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_word_serializer.sv
// Scoreboard bench for morse_word_serializer: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every accepted byte.
module tb_morse_word_serializer;
  import morse_word_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ce, word_ended, error, ascii_ready;
  logic [47:0] word;
  logic [7:0]  ascii_data;
  logic        ascii_valid, dropped, busy;

  int tests = 0;
  int fails = 0;
  int drop_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  morse_word_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .word        (word),
    .word_ended  (word_ended),
    .error       (error),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .dropped     (dropped),
    .busy        (busy)
  );

  // Monitor: stall stability, scoreboard compare, dropped pulse count
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        tests++;
        if (!ascii_valid || ascii_data !== stall_data) begin
          fails++;
          $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                   ascii_valid, ascii_data, stall_data);
        end
      end
      if (ascii_valid && ascii_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte: got %02h, required no output", ascii_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (ascii_data !== e) begin
            fails++;
            $display("FAIL byte: got %02h, required %02h", ascii_data, e);
          end
        end
      end
      stall_q    = ascii_valid && !ascii_ready;
      stall_data = ascii_data;
    end
    if (dropped === 1'b1) drop_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [47:0] mk(input int unsigned c0 = 0, input int unsigned c1 = 0,
                                     input int unsigned c2 = 0, input int unsigned c3 = 0,
                                     input int unsigned c4 = 0, input int unsigned c5 = 0,
                                     input int unsigned c6 = 0, input int unsigned c7 = 0);
    int unsigned c [8];
    logic [47:0] w;
    c = '{c0, c1, c2, c3, c4, c5, c6, c7};
    w = '0;
    for (int i = 0; i < 8; i++) w[i*6 +: 6] = 6'(c[i]);
    return w;
  endfunction

  // One-cycle word_ended pulse; returns one cycle later
  task automatic send_word(input logic [47:0] w, input logic e);
    word = w; error = e; word_ended = 1'b1;
    nxt();
    word_ended = 1'b0;
  endtask

  task automatic expect_bytes(input logic [7:0] b [$]);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      nxt();
      n++;
    end
    smp();
    tests++;
    if (exp_q.size() != 0 || busy) begin
      fails++;
      $display("FAIL drain_%s: %0d bytes outstanding busy=%0b, required 0 and 0",
               name, exp_q.size(), busy);
    end
  endtask

  initial begin
    int d0;
    rst = 1'b1; ce = 1'b1; word = '0; word_ended = 1'b0; error = 1'b0; ascii_ready = 1'b0;
    repeat (3) nxt();
    smp();
    chk("rst_valid", ascii_valid, 0);
    chk("rst_data", ascii_data, 8'h00);
    chk("rst_dropped", dropped, 0);
    chk("rst_busy", busy, 0);
    nxt(); rst = 1'b0;
    repeat (2) nxt();

    // Single word "AB": latency and throughput
    ascii_ready = 1'b1;
    expect_bytes('{8'h41, 8'h42, 8'h20});
    send_word(mk(CHAR_MORSE_A, CHAR_MORSE_B), 1'b0);
    smp();
    chk("t1_valid_T1", ascii_valid, 0);
    chk("t1_busy_T1", busy, 1);
    nxt(); smp();
    chk("t1_valid_T2", ascii_valid, 1);
    chk("t1_data_T2", ascii_data, 8'h41);
    nxt(); smp();
    chk("t1_data_T3", ascii_data, 8'h42);
    nxt(); smp();
    chk("t1_data_T4", ascii_data, 8'h20);
    nxt(); smp();
    chk("t1_busy_T5", busy, 0);
    nxt(); smp();
    chk("t1_busy_T6", busy, 0);
    chk("t1_valid_T6", ascii_valid, 0);
    drain("single");

    // Back-pressure: "SOS" with ready toggling
    ascii_ready = 1'b0;
    expect_bytes('{8'h53, 8'h4F, 8'h53, 8'h20});
    send_word(mk(CHAR_MORSE_S, CHAR_MORSE_O, CHAR_MORSE_S), 1'b0);
    for (int i = 0; i < 40 && (exp_q.size() != 0 || busy); i++) begin
      ascii_ready = ~ascii_ready;
      nxt();
    end
    ascii_ready = 1'b1;
    drain("sos");

    // Digits plus unknown code, then a full 8-character word
    expect_bytes('{8'h30, 8'h39, 8'h3F, 8'h20});
    send_word(mk(CHAR_MORSE_0, CHAR_MORSE_9, 50), 1'b0);
    nxt();
    expect_bytes('{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h20});
    send_word(mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b0);
    drain("digits_full");

    // Full buffer: third word dropped
    ascii_ready = 1'b0;
    d0 = drop_cnt;
    expect_bytes('{8'h41, 8'h20, 8'h42, 8'h20});
    send_word(mk(CHAR_MORSE_A), 1'b0);
    repeat (4) nxt();
    send_word(mk(CHAR_MORSE_B), 1'b0);
    repeat (4) nxt();
    smp();
    chk("full_drop_before", dropped, 0);
    send_word(mk(CHAR_MORSE_C), 1'b0);
    smp();
    chk("full_drop_T1", dropped, 1);
    nxt(); smp();
    chk("full_drop_T2", dropped, 0);
    nxt();
    ascii_ready = 1'b1;
    drain("full");
    chk("full_drop_count", 32'(drop_cnt - d0), 1);

    // Error word then clean word
    expect_bytes('{8'h23, 8'h20, 8'h54, 8'h20});
    send_word(mk(CHAR_MORSE_E), 1'b1);
    nxt();
    send_word(mk(CHAR_MORSE_T), 1'b0);
    drain("error");

    // Level held high counts once
    d0 = drop_cnt;
    expect_bytes('{8'h4B, 8'h20});
    word = mk(CHAR_MORSE_K); error = 1'b0; word_ended = 1'b1;
    repeat (20) nxt();
    word_ended = 1'b0;
    drain("level");

    // Pulse with ce=0 is ignored
    ce = 1'b0; word = mk(CHAR_MORSE_A);
    nxt(); word_ended = 1'b1;
    nxt(); word_ended = 1'b0;
    nxt(); ce = 1'b1;
    repeat (10) nxt();
    smp();
    chk("ce0_busy", busy, 0);

    // Empty word: no output, no drop
    send_word('0, 1'b0);
    repeat (5) nxt();
    smp();
    chk("empty_busy", busy, 0);
    chk("empty_drop_count", 32'(drop_cnt - d0), 0);

    // Reset during the second byte of a 6-character word
    nxt();
    ascii_ready = 1'b0;
    expect_bytes('{8'h41});
    send_word(mk(1, 2, 3, 4, 5, 6), 1'b0);
    nxt(); ascii_ready = 1'b1;
    nxt(); ascii_ready = 1'b0;
    smp();
    chk("rstmid_second", ascii_data, 8'h42);
    nxt(); rst = 1'b1;
    smp();
    chk("rstmid_hold", ascii_data, 8'h42);
    nxt(); rst = 1'b0;
    smp();
    chk("rstmid_valid", ascii_valid, 0);
    chk("rstmid_data", ascii_data, 8'h00);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_pending", exp_q.size(), 0);
    exp_q.delete();
    ascii_ready = 1'b1;
    repeat (10) nxt();
    expect_bytes('{8'h41, 8'h20});
    send_word(mk(CHAR_MORSE_A), 1'b0);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
